// File: rtl/inst_fetch_if.sv
// Instruction SRAM port between the fetch stage (master) and the synchronous SRAM (slave).
// Read data belongs to the request made at the previous clock edge.
interface inst_fetch_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: PC generation with stall-tolerant redirect capture, plus a one-entry
// buffer that keeps the SRAM read data for ID while ID/EX is stalled.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          stall,
    input  logic [32:0]         br_bus,
    inst_fetch_if.master        sram,
    output logic [32:0]         if_to_id_bus,
    output logic [31:0]         id_inst
);
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;

    logic [31:0] pc_r;
    logic        ce_r;
    logic        br_pend;
    logic [31:0] br_pend_addr;
    logic        ifid_ce;
    logic        hold_v;
    logic [31:0] hold_inst;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // A redirect caught during a PC stall outranks whatever decode presents on release.
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br_pend)
            next_pc = br_pend_addr;
        else if (br_e)
            next_pc = br_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r         <= RESET_PC - 32'd4;
            ce_r         <= 1'b0;
            br_pend      <= 1'b0;
            br_pend_addr <= 32'h0;
        end else if (stall[0] == NO_STOP) begin
            pc_r    <= next_pc;
            ce_r    <= 1'b1;
            br_pend <= 1'b0;
        end else if (br_e) begin
            br_pend      <= 1'b1;
            br_pend_addr <= br_addr;
        end
    end

    // Validity of the slot currently sitting in IF/ID; a bubble is inserted when
    // IF/ID holds but ID/EX advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ifid_ce <= 1'b0;
        else if (stall[1] == STOP && stall[2] == NO_STOP)
            ifid_ce <= 1'b0;
        else if (stall[1] == NO_STOP)
            ifid_ce <= ce_r;
    end

    // SRAM data is only valid for one cycle, so capture it the first time ID is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v    <= 1'b0;
            hold_inst <= 32'h0;
        end else if (stall[2] == NO_STOP) begin
            hold_v <= 1'b0;
        end else if (!hold_v && ifid_ce) begin
            hold_v    <= 1'b1;
            hold_inst <= sram.inst_sram_rdata;
        end
    end

    assign sram.inst_sram_en    = ce_r;
    assign sram.inst_sram_wen   = 4'b0000;
    assign sram.inst_sram_addr  = pc_r;
    assign sram.inst_sram_wdata = 32'h0;
    assign if_to_id_bus         = {ce_r, pc_r};
    assign id_inst              = hold_v ? hold_inst : sram.inst_sram_rdata;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, redirects, stall capture,
// ID hold buffer, asynchronous reset and PC wrap.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic [31:0] id_inst;
    int          n_cmp = 0;
    int          n_bad = 0;

    inst_fetch_if sram ();

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_bus       (br_bus),
        .sram         (sram),
        .if_to_id_bus (if_to_id_bus),
        .id_inst      (id_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_addr(input string tag, input logic [31:0] exp);
        chk(tag, {32'h0, sram.inst_sram_addr}, {32'h0, exp});
        chk({tag, "_en"}, {63'h0, sram.inst_sram_en}, 64'h1);
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 3'b000;
        br_bus = 33'h0;
        sram.inst_sram_rdata = 32'h1111_1111;
        #2;
        chk("rst_en",    {63'h0, sram.inst_sram_en}, 64'h0);
        chk("rst_addr",  {32'h0, sram.inst_sram_addr}, 64'hBFBF_FFFC);
        chk("rst_bus",   {31'h0, if_to_id_bus}, {31'h0, 1'b0, 32'hBFBF_FFFC});
        chk("rst_wen",   {60'h0, sram.inst_sram_wen}, 64'h0);
        chk("rst_wdata", {32'h0, sram.inst_sram_wdata}, 64'h0);
        chk("rst_inst",  {32'h0, id_inst}, 64'h1111_1111);
        tick();
        tick();
        rst = 1'b0;

        // Sequential fetch after reset
        tick(); chk_addr("seq0", 32'hBFC0_0000);
        chk("seq0_bus", {31'h0, if_to_id_bus}, {31'h0, 1'b1, 32'hBFC0_0000});
        tick(); chk_addr("seq1", 32'hBFC0_0004);
        tick(); chk_addr("seq2", 32'hBFC0_0008);
        tick(); chk_addr("seq3", 32'hBFC0_000C);

        // Redirect back to ...08, then the directed redirect to ...100 from ...08
        br_bus = {1'b1, 32'hBFC0_0008};
        tick(); br_bus = 33'h0; chk_addr("br_back", 32'hBFC0_0008);
        br_bus = {1'b1, 32'hBFC0_0100};
        tick(); br_bus = 33'h0; chk_addr("br_tgt", 32'hBFC0_0100);
        tick(); chk_addr("br_tgt4", 32'hBFC0_0104);

        // Redirect during PC stall is remembered and taken on release
        stall = 3'b001; br_bus = {1'b1, 32'hBFC0_0200};
        tick(); br_bus = 33'h0; chk_addr("stl1", 32'hBFC0_0104);
        tick(); chk_addr("stl2", 32'hBFC0_0104);
        tick(); chk_addr("stl3", 32'hBFC0_0104);
        stall = 3'b000;
        tick(); chk_addr("stl_rel", 32'hBFC0_0200);
        tick(); chk_addr("stl_clr", 32'hBFC0_0204);

        // Last redirect wins while stalled
        stall = 3'b001; br_bus = {1'b1, 32'hBFC0_0400};
        tick(); br_bus = {1'b1, 32'hBFC0_0500};
        tick(); br_bus = 33'h0; stall = 3'b000;
        tick(); chk_addr("last_wins", 32'hBFC0_0500);

        // Pending redirect beats a simultaneous new one
        stall = 3'b001; br_bus = {1'b1, 32'hBFC0_0600};
        tick(); stall = 3'b000; br_bus = {1'b1, 32'hBFC0_0700};
        tick(); br_bus = 33'h0; chk_addr("pend_prio", 32'hBFC0_0600);
        tick(); chk_addr("pend_prio4", 32'hBFC0_0604);

        // ID hold buffer keeps the first-stall-cycle word
        stall = 3'b111; sram.inst_sram_rdata = 32'h2402_0001;
        #1; chk("hold_c1", {32'h0, id_inst}, 64'h2402_0001);
        tick(); sram.inst_sram_rdata = 32'hDEAD_BEEF;
        chk("hold_c2", {32'h0, id_inst}, 64'h2402_0001);
        chk_addr("hold_pc", 32'hBFC0_0604);
        tick(); stall = 3'b000;
        chk("hold_c3", {32'h0, id_inst}, 64'h2402_0001);
        tick(); chk("hold_rel", {32'h0, id_inst}, 64'hDEAD_BEEF);

        // Bubble into ID: an invalid IF/ID slot is never captured
        stall = 3'b010;
        tick(); stall = 3'b111; sram.inst_sram_rdata = 32'hCAFE_0001;
        tick(); sram.inst_sram_rdata = 32'h1234_5678;
        #1; chk("bubble_nohold", {32'h0, id_inst}, 64'h1234_5678);

        // Async reset with pending redirect and held instruction
        stall = 3'b000;
        tick(); stall = 3'b111; br_bus = {1'b1, 32'hBFC0_0800};
        sram.inst_sram_rdata = 32'hAAAA_5555;
        tick(); br_bus = 33'h0; sram.inst_sram_rdata = 32'h0;
        chk("pre_rst_hold", {32'h0, id_inst}, 64'hAAAA_5555);
        sram.inst_sram_rdata = 32'h1357_2468;
        #3; rst = 1'b1;
        #1;
        chk("arst_en",   {63'h0, sram.inst_sram_en}, 64'h0);
        chk("arst_addr", {32'h0, sram.inst_sram_addr}, 64'hBFBF_FFFC);
        chk("arst_inst", {32'h0, id_inst}, 64'h1357_2468);
        tick(); rst = 1'b0; stall = 3'b000;
        tick(); chk_addr("arst_first", 32'hBFC0_0000);
        chk("arst_inst2", {32'h0, id_inst}, 64'h1357_2468);
        tick(); chk_addr("arst_second", 32'hBFC0_0004);

        // Wrap at the top of the address space
        br_bus = {1'b1, 32'hFFFF_FFF8};
        tick(); br_bus = 33'h0; chk_addr("wrap0", 32'hFFFF_FFF8);
        tick(); chk_addr("wrap1", 32'hFFFF_FFFC);
        tick(); chk_addr("wrap2", 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
